// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall detection and registered
// forwarding-select generation for the EX operand muxes.
module id_ex_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic [4:0]  id_rd,
    input  logic [63:0] id_rn_data,
    input  logic [63:0] id_rm_data,
    input  logic [63:0] id_imm,
    input  logic        id_alusrc,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic [2:0]  id_aluop,
    input  logic        flush,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    output logic        stall,
    output logic        ex_valid,
    output logic [4:0]  ex_rd,
    output logic [63:0] ex_rn_data,
    output logic [63:0] ex_rm_data,
    output logic [63:0] ex_imm,
    output logic        ex_alusrc,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic [2:0]  ex_aluop,
    output logic [1:0]  ex_fwd_a,
    output logic [1:0]  ex_fwd_b
);

    localparam logic [4:0] XZR = 5'd31;

    logic        ex_valid_r;
    logic [4:0]  ex_rd_r;
    logic [63:0] rn_data_r;
    logic [63:0] rm_data_r;
    logic [63:0] imm_r;
    logic        alusrc_r;
    logic        regwrite_r;
    logic        memread_r;
    logic        memwrite_r;
    logic [2:0]  aluop_r;
    logic [1:0]  fwd_a_r;
    logic [1:0]  fwd_b_r;

    logic        stall_s;
    logic        ex_fwd_ok_s;
    logic [1:0]  fwd_a_s;
    logic [1:0]  fwd_b_s;

    // EX/MEM beats MEM; a load in EX has no ALU result yet, so it never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       ex_ok,
        input logic [4:0] ex_dst,
        input logic       mem_ok,
        input logic [4:0] mem_dst
    );
        logic [1:0] sel;
        if (src == XZR) begin
            sel = 2'b00;
        end else if (ex_ok && (ex_dst == src)) begin
            sel = 2'b10;
        end else if (mem_ok && (mem_dst == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection and next-cycle forwarding selects.
    always_comb begin
        stall_s     = 1'b0;
        ex_fwd_ok_s = ex_valid_r & regwrite_r & ~memread_r;
        fwd_a_s     = fwd_sel(id_rn, ex_fwd_ok_s, ex_rd_r, mem_regwrite, mem_rd);
        fwd_b_s     = fwd_sel(id_rm, ex_fwd_ok_s, ex_rd_r, mem_regwrite, mem_rd);
        if (id_valid && ex_valid_r && memread_r && (ex_rd_r != XZR) &&
            ((ex_rd_r == id_rn) || (ex_rd_r == id_rm))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Pipeline register: bubble on flush or stall, otherwise capture decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_r <= 1'b0;
            ex_rd_r    <= 5'd0;
            rn_data_r  <= 64'd0;
            rm_data_r  <= 64'd0;
            imm_r      <= 64'd0;
            alusrc_r   <= 1'b0;
            regwrite_r <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            aluop_r    <= 3'd0;
            fwd_a_r    <= 2'b00;
            fwd_b_r    <= 2'b00;
        end else if (flush || stall_s) begin
            // Data and destination fields hold; only control is cleared.
            ex_valid_r <= 1'b0;
            alusrc_r   <= 1'b0;
            regwrite_r <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            aluop_r    <= 3'd0;
            fwd_a_r    <= 2'b00;
            fwd_b_r    <= 2'b00;
        end else begin
            ex_valid_r <= id_valid;
            ex_rd_r    <= id_rd;
            rn_data_r  <= id_rn_data;
            rm_data_r  <= id_rm_data;
            imm_r      <= id_imm;
            alusrc_r   <= id_alusrc & id_valid;
            regwrite_r <= id_regwrite & id_valid;
            memread_r  <= id_memread & id_valid;
            memwrite_r <= id_memwrite & id_valid;
            aluop_r    <= id_valid ? id_aluop : 3'd0;
            fwd_a_r    <= id_valid ? fwd_a_s : 2'b00;
            fwd_b_r    <= id_valid ? fwd_b_s : 2'b00;
        end
    end

    assign stall       = stall_s;
    assign ex_valid    = ex_valid_r;
    assign ex_rd       = ex_rd_r;
    assign ex_rn_data  = rn_data_r;
    assign ex_rm_data  = rm_data_r;
    assign ex_imm      = imm_r;
    assign ex_alusrc   = alusrc_r;
    assign ex_regwrite = regwrite_r;
    assign ex_memread  = memread_r;
    assign ex_memwrite = memwrite_r;
    assign ex_aluop    = aluop_r;
    assign ex_fwd_a    = fwd_a_r;
    assign ex_fwd_b    = fwd_b_r;

endmodule
